cpu_reg_sequencer: RTL and testbench
====================================

Name: cpu_reg_sequencer

Overview:
- Initiator side of the CPU register-file port. It takes register-transfer commands from the control unit over a valid/ready handshake.
- Supported commands: MOV, LDI, SWP, OUT. Each is expanded into a timed sequence of register-file read cycles (output enable + read select) and write cycles (write enable + write select + data).
- Sits between instruction decode and the register file. Returns a done pulse, plus the read value for OUT.

Parameters:
- WIDTH, 8, data width of registers and bus.
- SEL_W, 3, width of register select fields.
- NUM_REGS, 3, number of implemented registers; valid indices are 0..NUM_REGS-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0=MOV, 1=LDI, 2=SWP, 3=OUT.
- cmd_src  in  SEL_W  source register index.
- cmd_dst  in  SEL_W  destination register index.
- cmd_imm  in  WIDTH  immediate value for LDI.
- rf_sel_in  out  SEL_W  register-file write select.
- rf_sel_out  out  SEL_W  register-file read select.
- rf_enable_write  out  1  register-file write strobe.
- rf_output_enable  out  1  register-file bus drive enable.
- rf_data_in  out  WIDTH  write data to register file.
- rf_data_out  in  WIDTH  register-file read bus; combinational, valid in the same cycle as rf_output_enable.
- done  out  1  one-cycle pulse when a command completes.
- error  out  1  one-cycle pulse, coincident with done, on an illegal index.
- result  out  WIDTH  value read by the last OUT; held until the next OUT.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cmd_ready=1.
  - All rf_* outputs 0.
  - done=0, error=0, result=0, tmp_a=tmp_b=0.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, FIN.
- Handshake and state flow:
  - cmd_ready=1 only in IDLE. Accept when cmd_valid && cmd_ready; latch op/src/dst/imm.
  - From IDLE on accept:
    - illegal index -> FIN;
    - LDI -> WR_A with tmp_a<=imm;
    - MOV/SWP/OUT -> RD_A.
- Illegal index:
  - An index is illegal if >= NUM_REGS. MOV and SWP check src and dst; LDI checks dst; OUT checks src.
  - Illegal commands issue no rf access and produce done=1, error=1 in FIN.
- RD_A:
  - Drives rf_output_enable=1, rf_sel_out=src; captures rf_data_out into tmp_a at the edge.
  - Next state: OUT -> FIN with result<=rf_data_out; MOV -> WR_A; SWP -> RD_B.
- RD_B: rf_output_enable=1, rf_sel_out=dst; tmp_b<=rf_data_out; next state WR_A.
- WR_A: rf_enable_write=1, rf_sel_in=dst, rf_data_in=tmp_a. Next: SWP -> WR_B, else FIN.
- WR_B: rf_enable_write=1, rf_sel_in=src, rf_data_in=tmp_b; next FIN.
- FIN: done=1, error as decided; next IDLE, where cmd_ready is 1 again.
- Registered outputs: all rf_* strobes are decoded from the state register, glitch-free.
- Strobe exclusivity: rf_enable_write and rf_output_enable are never both 1. Both are 0 in IDLE and FIN.
- Cycles from accept edge to done pulse:
  - LDI = 2 cycles (WR_A, FIN);
  - MOV = 3;
  - OUT = 2;
  - SWP = 5;
  - illegal = 1.
- Throughput: the next command is accepted in the cycle after FIN (IDLE). No overlap.
- Degenerate commands:
  - SWP with src==dst is legal: both writes hit the same register with its original value, so its value is unchanged.
  - MOV with src==dst is legal; one read, then one write of the same value.
- cmd_* is ignored when not in IDLE.
- Reset mid-sequence aborts immediately: strobes drop asynchronously, no partial write completes, and no done pulse is produced.
- Unselected rf_sel_* outputs hold 0 when their strobe is low.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams OP_MOV/OP_LDI/OP_SWP/OP_OUT;
  - state encoding;
  - WIDTH and SEL_W defaults.
- Single module; no sub-module. The bench pairs it with the existing register file as the responder model.

Test Plan:
- Reset then LDI dst=1 imm=0x5A -> rf_enable_write=1 with sel_in=1, data_in=0x5A exactly 1 cycle after accept; done next cycle; regb=0x5A.
- LDI r0=0x11, then MOV src=0 dst=1 -> RD_A shows output_enable=1, sel_out=0; write cycle data_in=0x11 to sel_in=1; done 3 cycles after accept; regb=0x11.
- r0=0xA5, r1=0x3C, SWP src=0 dst=1 -> 2 reads then 2 writes; r0=0x3C, r1=0xA5; done at cycle 5; strobes never overlap.
- OUT src=1 (r1=0xA5) -> result=0xA5 with done 2 cycles after accept; result held across a following LDI.
- MOV src=5 dst=0 -> done=1 and error=1 one cycle after accept; no rf_* strobe asserted; r0 unchanged.
- Start SWP, assert reset_n=0 during WR_A -> rf_enable_write drops immediately; cmd_ready=1 and no done pulse after release; a subsequent LDI works normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-transfer datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_WIDTH    = 8;
    localparam int CPU_SEL_W    = 3;
    localparam int CPU_NUM_REGS = 3;

    localparam logic [1:0] OP_MOV = 2'd0;
    localparam logic [1:0] OP_LDI = 2'd1;
    localparam logic [1:0] OP_SWP = 2'd2;
    localparam logic [1:0] OP_OUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_FIN  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/cpu_reg_sequencer.sv
// Expands MOV/LDI/SWP/OUT commands into register-file read/write cycles.
// Latency: accept->done LDI 2, MOV 3, OUT 2, SWP 5, illegal index 1 cycle.
// Backpressure: cmd_ready high only in IDLE; one command in flight, no overlap.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op/src/dst/imm                command fields (latched on accept)
//   rf_sel_in/rf_enable_write/rf_data_in   register-file write port
//   rf_sel_out/rf_output_enable/rf_data_out register-file read port
//   done/error/result                 completion pulse, illegal-index flag, OUT value
module cpu_reg_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH    = CPU_WIDTH,
    parameter int SEL_W    = CPU_SEL_W,
    parameter int NUM_REGS = CPU_NUM_REGS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SEL_W-1:0] cmd_src,
    input  logic [SEL_W-1:0] cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [SEL_W-1:0] rf_sel_in,
    output logic [SEL_W-1:0] rf_sel_out,
    output logic             rf_enable_write,
    output logic             rf_output_enable,
    output logic [WIDTH-1:0] rf_data_in,
    input  logic [WIDTH-1:0] rf_data_out,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    seq_state_t       state_q, state_d;
    logic [1:0]       op_q;
    logic [SEL_W-1:0] src_q, dst_q;
    logic             err_q;
    logic [WIDTH-1:0] tmp_a, tmp_b, result_q;

    logic cmd_acc;
    logic src_bad, dst_bad, cmd_illegal;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign result  = result_q;

    // Only the index fields an opcode actually uses are range-checked.
    always_comb begin
        src_bad     = int'(cmd_src) >= NUM_REGS;
        dst_bad     = int'(cmd_dst) >= NUM_REGS;
        cmd_illegal = 1'b0;
        case (cmd_op)
            OP_MOV, OP_SWP: cmd_illegal = src_bad || dst_bad;
            OP_LDI:         cmd_illegal = dst_bad;
            default:        cmd_illegal = src_bad;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes. Strobes depend only on registered state and
    // latched fields, so they are glitch-free and drop with async reset.
    always_comb begin
        state_d          = state_q;
        cmd_ready        = 1'b0;
        rf_sel_in        = '0;
        rf_sel_out       = '0;
        rf_enable_write  = 1'b0;
        rf_output_enable = 1'b0;
        rf_data_in       = '0;
        done             = 1'b0;
        error            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_illegal)          state_d = ST_FIN;
                    else if (cmd_op == OP_LDI) state_d = ST_WR_A;
                    else                      state_d = ST_RD_A;
                end
            end
            ST_RD_A: begin
                rf_output_enable = 1'b1;
                rf_sel_out       = src_q;
                if (op_q == OP_OUT)      state_d = ST_FIN;
                else if (op_q == OP_MOV) state_d = ST_WR_A;
                else                     state_d = ST_RD_B;
            end
            ST_RD_B: begin
                rf_output_enable = 1'b1;
                rf_sel_out       = dst_q;
                state_d          = ST_WR_A;
            end
            ST_WR_A: begin
                rf_enable_write = 1'b1;
                rf_sel_in       = dst_q;
                rf_data_in      = tmp_a;
                state_d         = (op_q == OP_SWP) ? ST_WR_B : ST_FIN;
            end
            ST_WR_B: begin
                rf_enable_write = 1'b1;
                rf_sel_in       = src_q;
                rf_data_in      = tmp_b;
                state_d         = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                error   = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch and data capture. tmp_a doubles as the LDI immediate
    // holder so WR_A always writes tmp_a regardless of opcode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_MOV;
            src_q    <= '0;
            dst_q    <= '0;
            err_q    <= 1'b0;
            tmp_a    <= '0;
            tmp_b    <= '0;
            result_q <= '0;
        end else begin
            if (cmd_acc) begin
                op_q  <= cmd_op;
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                err_q <= cmd_illegal;
                if (cmd_op == OP_LDI) begin
                    tmp_a <= cmd_imm;
                end
            end
            if (state_q == ST_RD_A) begin
                tmp_a <= rf_data_out;
                if (op_q == OP_OUT) begin
                    result_q <= rf_data_out;
                end
            end
            if (state_q == ST_RD_B) begin
                tmp_b <= rf_data_out;
            end
        end
    end

endmodule

// File: tb/tb_cpu_reg_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_reg_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_src = 3'd0;
    logic [2:0] cmd_dst = 3'd0;
    logic [7:0] cmd_imm = 8'd0;
    logic [2:0] rf_sel_in, rf_sel_out;
    logic       rf_enable_write, rf_output_enable;
    logic [7:0] rf_data_in, rf_data_out;
    logic       done, error;
    logic [7:0] result;

    always #5 clk = ~clk;

    cpu_reg_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rf_sel_in(rf_sel_in), .rf_sel_out(rf_sel_out),
        .rf_enable_write(rf_enable_write), .rf_output_enable(rf_output_enable),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out),
        .done(done), .error(error), .result(result)
    );

    // Register-file responder: combinational read, write on rising edge.
    logic [7:0] rf_mem [3] = '{default: 8'h00};
    always @(posedge clk) begin
        if (rf_enable_write && int'(rf_sel_in) < 3) rf_mem[rf_sel_in] <= rf_data_in;
    end
    always_comb begin
        rf_data_out = 8'h00;
        if (rf_output_enable && int'(rf_sel_out) < 3) rf_data_out = rf_mem[rf_sel_out];
    end

    typedef struct {
        logic [1:0] op;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] imm;
        int         lat;
        logic       err;
        logic [7:0] res;
    } vec_t;

    typedef struct {
        int         lat;
        logic       err;
        logic [7:0] res;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[16];
    logic [7:0] exp_regs [3] = '{default: 8'h00};
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Continuous protocol checks while out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            check("strobe_overlap", {31'd0, rf_enable_write && rf_output_enable}, 32'd0);
            if (!rf_enable_write)  check("sel_in_idle",  {29'd0, rf_sel_in},  32'd0);
            if (!rf_output_enable) check("sel_out_idle", {29'd0, rf_sel_out}, 32'd0);
            if (error)             check("error_wo_done", {31'd0, done}, 32'd1);
        end
    end

    task automatic issue(input vec_t v);
        exp_t e, got;
        int   cyc;
        int   first_oe, first_we;
        logic [2:0] oe_sel, we_sel;
        logic [7:0] we_dat;
        bit   any_strobe;
        e.lat = v.lat; e.err = v.err; e.res = v.res;
        sb.push_back(e);
        first_oe = 0; first_we = 0; any_strobe = 0;
        oe_sel = 3'd0; we_sel = 3'd0; we_dat = 8'd0;
        @(negedge clk);
        check("ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_src = v.src; cmd_dst = v.dst; cmd_imm = v.imm;
        @(posedge clk);
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                cmd_op = 2'($urandom_range(3)); cmd_src = 3'($urandom_range(7));
            end
            if (rf_output_enable || rf_enable_write) any_strobe = 1;
            if (rf_output_enable && first_oe == 0) begin first_oe = cyc; oe_sel = rf_sel_out; end
            if (rf_enable_write && first_we == 0) begin
                first_we = cyc; we_sel = rf_sel_in; we_dat = rf_data_in;
            end
            if (done) break;
        end
        if (cyc > 20) check("done_timeout", 32'd0, 32'd1);
        got = sb.pop_front();
        check("latency", cyc, got.lat);
        check("error", {31'd0, error}, {31'd0, got.err});
        check("result", {24'd0, result}, {24'd0, got.res});
        if (v.err) begin
            check("illegal_no_strobe", {31'd0, any_strobe}, 32'd0);
        end else if (v.op == OP_LDI) begin
            check("ldi_we_cycle", first_we, 1);
            check("ldi_we_sel", {29'd0, we_sel}, {29'd0, v.dst});
            check("ldi_we_data", {24'd0, we_dat}, {24'd0, v.imm});
        end else begin
            check("rd_oe_cycle", first_oe, 1);
            check("rd_oe_sel", {29'd0, oe_sel}, {29'd0, v.src});
        end
        if (!v.err) begin
            logic [7:0] a, b;
            a = exp_regs[v.src]; b = exp_regs[v.dst];
            case (v.op)
                OP_LDI: exp_regs[v.dst] = v.imm;
                OP_MOV: exp_regs[v.dst] = a;
                OP_SWP: begin exp_regs[v.dst] = a; exp_regs[v.src] = b; end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reg%0d", i), {24'd0, rf_mem[i]}, {24'd0, exp_regs[i]});
    endtask

    initial begin
        vec_t v;
        bit   saw_done;
        //         op      src   dst   imm    lat err res
        vecs[0]  = '{OP_LDI, 3'd0, 3'd1, 8'h5A, 2, 0, 8'h00};
        vecs[1]  = '{OP_LDI, 3'd0, 3'd0, 8'h11, 2, 0, 8'h00};
        vecs[2]  = '{OP_MOV, 3'd0, 3'd1, 8'h00, 3, 0, 8'h00};
        vecs[3]  = '{OP_LDI, 3'd0, 3'd0, 8'hA5, 2, 0, 8'h00};
        vecs[4]  = '{OP_LDI, 3'd0, 3'd1, 8'h3C, 2, 0, 8'h00};
        vecs[5]  = '{OP_SWP, 3'd0, 3'd1, 8'h00, 5, 0, 8'h00};
        vecs[6]  = '{OP_OUT, 3'd1, 3'd0, 8'h00, 2, 0, 8'hA5};
        vecs[7]  = '{OP_LDI, 3'd0, 3'd2, 8'h77, 2, 0, 8'hA5};
        vecs[8]  = '{OP_MOV, 3'd5, 3'd0, 8'h00, 1, 1, 8'hA5};
        vecs[9]  = '{OP_SWP, 3'd2, 3'd2, 8'h00, 5, 0, 8'hA5};
        vecs[10] = '{OP_MOV, 3'd2, 3'd2, 8'h00, 3, 0, 8'hA5};
        vecs[11] = '{OP_OUT, 3'd3, 3'd0, 8'h00, 1, 1, 8'hA5};
        vecs[12] = '{OP_LDI, 3'd0, 3'd7, 8'hEE, 1, 1, 8'hA5};
        vecs[13] = '{OP_SWP, 3'd0, 3'd3, 8'h00, 1, 1, 8'hA5};
        vecs[14] = '{OP_OUT, 3'd0, 3'd1, 8'h00, 2, 0, 8'h3C};
        vecs[15] = '{OP_OUT, 3'd2, 3'd0, 8'h00, 2, 0, 8'h77};

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_we", {31'd0, rf_enable_write}, 32'd0);
        check("rst_oe", {31'd0, rf_output_enable}, 32'd0);
        check("rst_sel", {26'd0, rf_sel_in, rf_sel_out}, 32'd0);
        check("rst_data_in", {24'd0, rf_data_in}, 32'd0);
        check("rst_done_err", {30'd0, done, error}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) issue(vecs[i]);

        // Abort a SWP during its first write: strobe must drop at once.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SWP; cmd_src = 3'd0; cmd_dst = 3'd1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wr_a", {31'd0, rf_enable_write}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_we_drop", {31'd0, rf_enable_write}, 32'd0);
        check("abort_oe_low", {31'd0, rf_output_enable}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("abort_result_clr", {24'd0, result}, 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("abort_reg%0d", i), {24'd0, rf_mem[i]}, {24'd0, exp_regs[i]});

        v = '{OP_LDI, 3'd0, 3'd0, 8'hC3, 2, 0, 8'h00};
        issue(v);
        v = '{OP_OUT, 3'd0, 3'd0, 8'h00, 2, 0, 8'hC3};
        issue(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
